// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - instruction fetch stage: PC, ROM request/ack handshake, instruction buffer
// Optional IF_ALIGN_CHECK_EN: misaligned fetch targets produce an if_excp entry instead of a ROM fetch.
module if_fetch_unit #(
    parameter int                ADDR_W     = 32,
    parameter int                DATA_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter int                FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              branch_flag,
    input  logic [ADDR_W-1:0] branch_target,
    output logic              rom_ce,
    output logic              rom_req,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic              rom_ack,
    input  logic [DATA_W-1:0] rom_data,
    output logic              if_valid,
    output logic [ADDR_W-1:0] if_pc,
`ifdef IF_ALIGN_CHECK_EN
    output logic              if_excp,
`endif
    output logic [DATA_W-1:0] if_inst
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, RUN, DROP} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] pc, pc_nxt, drop_addr, target_ld;
    logic [ADDR_W-1:0] fifo_pc   [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_inst [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              fifo_full, fetch_blocked, drop_enter;
    logic              push, push_data, pop, entry_excp;

`ifdef IF_ALIGN_CHECK_EN
    logic excp_done, push_excp;
    logic fifo_excp [FIFO_DEPTH];

    assign target_ld     = branch_target;
    assign fetch_blocked = (pc[1:0] != 2'b00);
    assign push_excp     = (state == RUN) && fetch_blocked && !excp_done && !fifo_full && !branch_flag;
    assign entry_excp    = push_excp;
    assign if_excp       = if_valid ? fifo_excp[rd_ptr] : 1'b0;

    // One exception entry per misaligned target; a new redirect re-arms it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            excp_done <= 1'b0;
        end else if (branch_flag) begin
            excp_done <= 1'b0;
        end else if (push_excp) begin
            excp_done <= 1'b1;
        end
    end
`else
    assign target_ld     = branch_target & ~ADDR_W'(3);
    assign fetch_blocked = 1'b0;
    assign entry_excp    = 1'b0;
`endif

    assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
    assign if_valid   = (count != '0);
    assign rom_ce     = (state != IDLE);
    assign rom_addr   = (state == DROP) ? drop_addr : pc;
    assign pop        = if_valid && !stall && !branch_flag;
    assign push_data  = (state == RUN) && rom_req && rom_ack && !branch_flag;
    assign push       = push_data || entry_excp;
    assign drop_enter = (state == RUN) && branch_flag && rom_req && !rom_ack;
    assign if_pc      = if_valid ? fifo_pc[rd_ptr] : '0;
    assign if_inst    = if_valid ? fifo_inst[rd_ptr] : '0;

    always_comb begin
        rom_req = 1'b0;
        case (state)
            RUN:     rom_req = !fifo_full && !fetch_blocked;
            DROP:    rom_req = 1'b1;
            default: rom_req = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        case (state)
            IDLE: state_nxt = RUN;
            RUN: begin
                if (branch_flag) begin
                    pc_nxt = target_ld;
                    if (rom_req && !rom_ack) begin
                        state_nxt = DROP;
                    end
                end else if (rom_req && rom_ack) begin
                    pc_nxt = pc + ADDR_W'(4);
                end
            end
            DROP: begin
                // The in-flight word is discarded; pc already holds the redirect target.
                if (rom_ack) begin
                    state_nxt = RUN;
                end
                if (branch_flag) begin
                    pc_nxt = target_ld;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            drop_addr <= RESET_PC;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            if (drop_enter) begin
                drop_addr <= pc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (branch_flag) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc[wr_ptr]   <= pc;
            fifo_inst[wr_ptr] <= entry_excp ? '0 : rom_data;
`ifdef IF_ALIGN_CHECK_EN
            fifo_excp[wr_ptr] <= entry_excp;
`endif
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - directed bench for if_fetch_unit with an in-order fetch-stream model
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        rst, stall, branch_flag, rom_ack;
    logic [31:0] branch_target, rom_data;
    logic        rom_ce, rom_req, if_valid;
    logic [31:0] rom_addr, if_pc, if_inst;
`ifdef IF_ALIGN_CHECK_EN
    logic        if_excp;
`endif

    always #5 clk = ~clk;

    if_fetch_unit dut (
        .clk(clk), .rst(rst), .stall(stall),
        .branch_flag(branch_flag), .branch_target(branch_target),
        .rom_ce(rom_ce), .rom_req(rom_req), .rom_addr(rom_addr),
        .rom_ack(rom_ack), .rom_data(rom_data),
        .if_valid(if_valid), .if_pc(if_pc),
`ifdef IF_ALIGN_CHECK_EN
        .if_excp(if_excp),
`endif
        .if_inst(if_inst)
    );

    int          vectors = 0;
    int          miscompares = 0;
    int          lat = 1;
    int          wait_cnt = 0;
    int          n, nvalid;
    logic [31:0] exp_pc = 32'h0;
    logic        req_prev = 1'b0;
    logic [31:0] req_addr_prev = 32'h0;
    logic        hold_prev = 1'b0;
    logic [31:0] hold_pc = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge with inputs already set for the coming posedge.
    task automatic tick();
        if (rom_req && rst) begin
            if (wait_cnt >= lat - 1) begin
                rom_ack  = 1'b1;
                rom_data = rom_addr ^ 32'hFFFF_FFFF;
                wait_cnt = 0;
            end else begin
                rom_ack  = 1'b0;
                wait_cnt++;
            end
        end else begin
            rom_ack  = 1'b0;
            wait_cnt = 0;
        end
        if (req_prev) begin
            chk("req_held", rom_req, 1);
            chk("addr_held", rom_addr, req_addr_prev);
        end
        req_prev      = rom_req && !rom_ack;
        req_addr_prev = rom_addr;
        if (hold_prev) begin
            chk("hold_valid", if_valid, 1);
            chk("hold_pc", if_pc, hold_pc);
        end
        hold_prev = if_valid && stall && !branch_flag;
        hold_pc   = if_pc;
        if (if_valid && !stall && !branch_flag) begin
            chk("pc_seq", if_pc, exp_pc);
            chk("inst_seq", if_inst, exp_pc ^ 32'hFFFF_FFFF);
`ifdef IF_ALIGN_CHECK_EN
            chk("excp_seq", if_excp, 0);
`endif
            exp_pc = exp_pc + 32'd4;
        end
        if (branch_flag) begin
            exp_pc = branch_target & ~32'h3;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) tick();
    endtask

    task automatic branch(input logic [31:0] target);
        branch_flag   = 1'b1;
        branch_target = target;
        tick();
        branch_flag   = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_ce"}, rom_ce, 0);
        chk({tag, "_req"}, rom_req, 0);
        chk({tag, "_addr"}, rom_addr, 0);
        chk({tag, "_valid"}, if_valid, 0);
        chk({tag, "_pc"}, if_pc, 0);
        chk({tag, "_inst"}, if_inst, 0);
    endtask

    initial begin
        rst = 1'b0; stall = 1'b0; branch_flag = 1'b0;
        branch_target = 32'h0; rom_ack = 1'b0; rom_data = 32'h0;
        repeat (2) @(negedge clk);
        chk_reset("rst");
        rst = 1'b1;

        // Boot and streaming at one fetch per cycle
        tick();
        chk("boot_valid", if_valid, 0);
        chk("boot_req", rom_req, 1);
        chk("boot_ce", rom_ce, 1);
        chk("boot_addr", rom_addr, 0);
        tick();
        chk("first_valid", if_valid, 1);
        chk("first_pc", if_pc, 0);
        chk("first_inst", if_inst, 32'hFFFF_FFFF);
        tick();
        chk("pc_4", if_pc, 32'h4);
        tick();
        chk("pc_8", if_pc, 32'h8);

        // Stall: buffer fills to two and the request drops
        stall = 1'b1;
        tick();
        chk("full_req", rom_req, 0);
        run(4);
        chk("stall_pc", if_pc, 32'h8);
        stall = 1'b0;
        run(4);

        // Redirect with address wrap
        branch(32'hFFFF_FFF8);
        chk("br_flush", if_valid, 0);
        chk("br_req", rom_req, 1);
        chk("br_addr", rom_addr, 32'hFFFF_FFF8);
        tick();
        chk("br_lat_valid", if_valid, 1);
        chk("br_lat_pc", if_pc, 32'hFFFF_FFF8);
        tick();
        chk("wrap_fffc", if_pc, 32'hFFFF_FFFC);
        tick();
        chk("wrap_0", if_pc, 32'h0);
        run(2);

        // Slow ROM: one instruction per three cycles
        branch(32'h0);
        lat = 3;
        run(3);
        nvalid = 0;
        for (int i = 0; i < 9; i++) begin
            if (if_valid) nvalid++;
            tick();
        end
        chk("valid_rate", 32'(nvalid), 3);

        // Redirect while the fetch to 0x14 is in flight
        for (int i = 0; i < 40 && !(rom_req && rom_addr == 32'h14); i++) tick();
        chk("reach_14", {31'b0, rom_req && rom_addr == 32'h14}, 1);
        chk("fresh_14", 32'(wait_cnt), 0);
        branch(32'h100);
        chk("drop_req", rom_req, 1);
        chk("drop_addr", rom_addr, 32'h14);
        chk("drop_flush", if_valid, 0);
        n = 0;
        for (int i = 0; i < 10 && rom_addr != 32'h100; i++) begin
            tick();
            n++;
        end
        chk("drop_exit_ticks", 32'(n), 2);
        for (int i = 0; i < 10 && !if_valid; i++) tick();
        chk("after_drop_pc", if_pc, 32'h100);

        // Branch coincident with ack, then a second branch inside DROP
        for (int i = 0; i < 10 && !(rom_req && wait_cnt == lat - 1); i++) tick();
        chk("reach_ack", {31'b0, rom_req && wait_cnt == lat - 1}, 1);
        branch(32'h180);
        chk("coinc_req", rom_req, 1);
        chk("coinc_addr", rom_addr, 32'h180);
        branch(32'h1C0);
        chk("drop2_addr", rom_addr, 32'h180);
        branch(32'h200);
        chk("drop3_addr", rom_addr, 32'h180);
        tick();
        chk("drop_exit_200", rom_addr, 32'h200);
        for (int i = 0; i < 10 && !if_valid; i++) tick();
        chk("post_drop_pc", if_pc, 32'h200);
        run(6);

        // Asynchronous reset mid-request, then a stray ack
        for (int i = 0; i < 10 && !(rom_req && wait_cnt == 1); i++) tick();
        #2 rst = 1'b0;
        #1 chk_reset("arst");
        rom_ack  = 1'b1;
        rom_data = 32'hDEAD_BEEF;
        @(posedge clk);
        @(negedge clk);
        chk_reset("stray");
        rom_ack   = 1'b0;
        rst       = 1'b1;
        lat       = 1;
        wait_cnt  = 0;
        req_prev  = 1'b0;
        hold_prev = 1'b0;
        exp_pc    = 32'h0;
        tick();
        chk("rst2_req", rom_req, 1);
        chk("rst2_addr", rom_addr, 32'h0);
        tick();
        chk("rst2_valid", if_valid, 1);
        chk("rst2_pc", if_pc, 32'h0);
        run(3);

        // Misaligned redirect target
`ifdef IF_ALIGN_CHECK_EN
        stall = 1'b1;
        branch(32'h102);
        chk("mis_flush", if_valid, 0);
        chk("mis_noreq0", rom_req, 0);
        tick();
        chk("mis_valid", if_valid, 1);
        chk("mis_pc", if_pc, 32'h102);
        chk("mis_inst", if_inst, 32'h0);
        chk("mis_excp", if_excp, 1);
        for (int i = 0; i < 3; i++) begin
            chk("mis_noreq", rom_req, 0);
            tick();
        end
        stall = 1'b0;
        branch(32'h300);
        chk("mis_resume_addr", rom_addr, 32'h300);
        tick();
        chk("mis_resume_pc", if_pc, 32'h300);
        chk("mis_resume_excp", if_excp, 0);
        run(3);
`else
        branch(32'h102);
        chk("mask_addr", rom_addr, 32'h100);
        tick();
        chk("mask_pc", if_pc, 32'h100);
        run(3);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction fetch stage that owns the program counter and issues requests to the instruction ROM through a request/acknowledge handshake.
- Returned instructions are buffered in a small FIFO and each is presented with its PC to the IF/ID pipeline register.
- Supports downstream stall and branch redirect.
- A redirect discards any fetch that is still in flight.

Parameters:
- ADDR_W, 32, instruction address width.
- DATA_W, 32, instruction width.
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- FIFO_DEPTH, 2, instruction buffer entries (power of two, ≥2).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; asynchronous, active-low.
- stall  in  1  downstream cannot accept; hold the current output.
- branch_flag  in  1  redirect request, single-cycle pulse.
- branch_target  in  ADDR_W  redirect PC.
- rom_ce  out  1  ROM chip enable.
- rom_req  out  1  fetch request, held until acknowledged.
- rom_addr  out  ADDR_W  fetch address, stable while rom_req=1.
- rom_ack  in  1  ROM has returned rom_data this cycle.
- rom_data  in  DATA_W  instruction word.
- if_valid  out  1  if_pc/if_inst hold a valid instruction.
- if_pc  out  ADDR_W  PC of the presented instruction.
- if_inst  out  DATA_W  presented instruction.

Behaviour:
- Reset (rst=0, asynchronous):
  - Outputs: rom_ce=0, rom_req=0, rom_addr=RESET_PC, if_valid=0, if_pc=0, if_inst=0.
  - Internal: pc=RESET_PC, FIFO empty, state=IDLE.
  - Reset asserted mid-transaction abandons the outstanding request; any later rom_ack is ignored while in IDLE.
- States:
  - IDLE: rom_ce=0. Moves to RUN on the first clock after reset deasserts.
  - RUN: rom_ce=1. rom_req=1 whenever (fifo_count + outstanding) < FIFO_DEPTH. At most one request is outstanding.
  - DROP: rom_req is held until rom_ack, and the returned data is discarded.
- Handshake:
  - Once raised, rom_req and rom_addr stay constant until the cycle in which rom_ack=1.
  - On ack in RUN: push {pc, rom_data} into the FIFO, then pc <= pc+4 (modulo 2^ADDR_W, wrap at all-ones).
  - rom_req may remain high in the next cycle, with rom_addr = new pc, if space remains. This allows one fetch per cycle with a zero-wait ROM.
  - rom_ack while rom_req=0 is ignored.
- Output:
  - if_valid = FIFO non-empty; if_pc/if_inst = FIFO head (registered, so no combinational path from rom_data).
  - Pop when if_valid=1 and stall=0.
  - A push into an empty FIFO becomes visible on the next cycle.
  - Push and pop in the same cycle keep the count unchanged.
  - A full FIFO suppresses rom_req. Overflow is impossible by construction.
- Redirect (branch_flag=1):
  - FIFO flushed (if_valid=0 next cycle) and pc <= branch_target.
  - No request outstanding: the next cycle issues a request at the target.
  - Request outstanding, no ack this cycle: enter DROP. On the ack, discard the data, return to RUN, and request the target in the following cycle.
  - Ack in the same cycle as the branch: the acked data is discarded, no DROP is needed, and the next request goes to the target.
  - Branch while in DROP: the target is updated and the unit stays in DROP.
  - Branch has priority over stall and over pop.
- Latency: branch to the first redirected if_valid is 2 cycles with a zero-wait ROM (no in-flight fetch).

Optional Feature:
- Macro: IF_ALIGN_CHECK_EN.
- With the macro defined:
  - Adds output if_excp (1 bit), which travels in the FIFO alongside the entry.
  - If a redirect target or RESET_PC has [1:0]≠0: no ROM request is issued for it, an entry {pc, 32'h0} with if_excp=1 is pushed, and fetching stops (no further requests) until the next branch_flag.
  - if_excp resets to 0.
- Without the macro: no if_excp port; target bits [1:0] are forced to 0 when loaded into pc.

Test Plan:
- Reset release, ROM acks every cycle with data=addr^32'hFFFF_FFFF, stall=0 → if_pc sequence 0,4,8,…, one per cycle after the first valid; if_inst matches.
- stall=1 held for 5 cycles from the cycle if_pc=8 → if_pc/if_inst hold 8, rom_req drops once 2 entries are buffered, and the sequence resumes 8,C,10 with no loss or duplication.
- ROM with 3-cycle ack latency → rom_addr is constant while rom_req=1, and if_valid toggles at the fetch rate.
- branch_flag with target 32'h100 while a fetch to 0x14 is outstanding → data for 0x14 never appears, the next if_pc is 0x100, and DROP is exited on the ack.
- branch_flag coincident with rom_ack, and a second branch (0x200) during DROP → only instructions from 0x200 onward are presented.
- Assert rst asynchronously mid-request, then pulse a stray rom_ack → all outputs hold their reset values and fetching restarts at RESET_PC.
- With IF_ALIGN_CHECK_EN defined, branch to 0x102 → one entry with if_pc=0x102, if_excp=1, and no ROM request until the next branch.
